// File: rtl/spu_pkg.sv
// spu_pkg: shared constants, stage record and latency clamp for the SPU
// even-pipe result staging pipeline (spu_result_pipe, spu_fwd_match).
package spu_pkg;

  localparam int DATA_W     = 128;
  localparam int ADDR_W     = 7;
  localparam int PIPE_DEPTH = 7;
  localparam int LAT_W      = 3;

  // One in-flight result. lat is stored already clamped to 1..PIPE_DEPTH.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rt;
    logic [LAT_W-1:0]  lat;
    logic [DATA_W-1:0] data;
  } spu_stage_t;

  // Latency 0 behaves as 1, anything beyond the pipe depth as the pipe depth.
  function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
    if (lat == '0)                return LAT_W'(1);
    if (int'(lat) > PIPE_DEPTH)   return LAT_W'(PIPE_DEPTH);
    return lat;
  endfunction

endpackage

// File: rtl/spu_fwd_match.sv
// spu_fwd_match: per-read-port lookup over the result staging pipeline.
// Picks the youngest valid stage whose rt matches rd_addr and reports
// whether it can be forwarded (hit/data) or must stall (pending).
// Ports:
//   stg      in  stage array, index 1 = youngest
//   rd_addr  in  operand register address
//   hit      out forwarded value valid
//   pending  out matching entry not yet available
//   data     out forwarded value (0 unless hit)
// Config: SPU_RESULT_FWD_EN defined -> forwarding; undefined -> no
// forwarding, any match raises pending.
module spu_fwd_match
  import spu_pkg::*;
(
  input  spu_stage_t [PIPE_DEPTH:1] stg,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic                      hit,
  output logic                      pending,
  output logic [DATA_W-1:0]         data
);

  logic              found;
  logic              avail;
  logic [DATA_W-1:0] sel;

  // Scan oldest to youngest so the youngest match wins by overwriting.
  always_comb begin
    found = 1'b0;
    avail = 1'b0;
    sel   = '0;
    for (int k = PIPE_DEPTH; k >= 1; k--) begin
      if (stg[k].valid && stg[k].rt == rd_addr) begin
        found = 1'b1;
        avail = (k >= int'(stg[k].lat));
        sel   = stg[k].data;
      end
    end
  end

`ifdef SPU_RESULT_FWD_EN
  assign hit     = found & avail;
  assign pending = found & ~avail;
  assign data    = (found & avail) ? sel : '0;
`else
  logic unused_fwd;
  assign unused_fwd = ^{avail, sel};
  assign hit     = 1'b0;
  assign pending = found;
  assign data    = '0;
`endif

endmodule

// File: rtl/spu_result_pipe.sv
// spu_result_pipe: even-pipe result staging. Captures ALU results with
// target register and latency, carries them PIPE_DEPTH stages to a single
// writeback port, and serves forwarding / RAW stall to three read ports.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_rt/in_lat/in_result  result capture
//   hold                       freeze pipe (no advance, no capture, no wb)
//   flush                      kill stages 1..PIPE_DEPTH-1; stage PIPE_DEPTH
//                              still commits; overrides hold
//   rd_addr_a/b/c              operand lookup addresses
//   fwd_hit_*/fwd_data_*       forwarded operand
//   stall_req                  some operand matches an unavailable entry
//   wb_en/wb_rt/wb_data        register-file write port
// Config: SPU_RESULT_FWD_EN enables forwarding (see spu_fwd_match).
module spu_result_pipe
  import spu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [LAT_W-1:0]  in_lat,
  input  logic [DATA_W-1:0] in_result,
  input  logic              hold,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic [ADDR_W-1:0] rd_addr_c,
  output logic              fwd_hit_a,
  output logic              fwd_hit_b,
  output logic              fwd_hit_c,
  output logic [DATA_W-1:0] fwd_data_a,
  output logic [DATA_W-1:0] fwd_data_b,
  output logic [DATA_W-1:0] fwd_data_c,
  output logic              stall_req,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_rt,
  output logic [DATA_W-1:0] wb_data
);

  localparam int NPORT = 3;

  spu_stage_t [PIPE_DEPTH:1] stg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg <= '0;
    end else if (flush) begin
      // Stage PIPE_DEPTH retires this edge anyway, so clearing all is exact.
      for (int k = 1; k <= PIPE_DEPTH; k++) stg[k].valid <= 1'b0;
    end else if (!hold) begin
      stg[1] <= '{valid: in_valid, rt: in_rt, lat: clamp_lat(in_lat), data: in_result};
      for (int k = 2; k <= PIPE_DEPTH; k++) stg[k] <= stg[k-1];
    end
  end

  assign wb_en   = stg[PIPE_DEPTH].valid & (flush | ~hold);
  assign wb_rt   = stg[PIPE_DEPTH].rt;
  assign wb_data = stg[PIPE_DEPTH].data;

  logic [NPORT-1:0][ADDR_W-1:0] rd;
  logic [NPORT-1:0]             hit;
  logic [NPORT-1:0]             pend;
  logic [NPORT-1:0][DATA_W-1:0] fdat;

  assign rd = {rd_addr_c, rd_addr_b, rd_addr_a};

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    spu_fwd_match u_match (
      .stg     (stg),
      .rd_addr (rd[p]),
      .hit     (hit[p]),
      .pending (pend[p]),
      .data    (fdat[p])
    );
  end

  assign fwd_hit_a  = hit[0];
  assign fwd_hit_b  = hit[1];
  assign fwd_hit_c  = hit[2];
  assign fwd_data_a = fdat[0];
  assign fwd_data_b = fdat[1];
  assign fwd_data_c = fdat[2];
  assign stall_req  = |pend;

endmodule

// File: tb/tb_spu_result_pipe.sv
module tb_spu_result_pipe;
  localparam int PD = 7;

  logic         clk = 0;
  logic         rst_n = 0;
  logic         in_valid = 0;
  logic [6:0]   in_rt = 0;
  logic [2:0]   in_lat = 0;
  logic [127:0] in_result = 0;
  logic         hold = 0, flush = 0;
  logic [6:0]   rd_addr_a = 0, rd_addr_b = 0, rd_addr_c = 0;
  logic         fwd_hit_a, fwd_hit_b, fwd_hit_c, stall_req, wb_en;
  logic [127:0] fwd_data_a, fwd_data_b, fwd_data_c, wb_data;
  logic [6:0]   wb_rt;

  int checks = 0, errors = 0;

  spu_result_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_rt(in_rt), .in_lat(in_lat),
    .in_result(in_result), .hold(hold), .flush(flush),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_addr_c(rd_addr_c),
    .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b), .fwd_hit_c(fwd_hit_c),
    .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b), .fwd_data_c(fwd_data_c),
    .stall_req(stall_req), .wb_en(wb_en), .wb_rt(wb_rt), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each in-flight result is tracked by its age = edges since capture.
  typedef struct {
    bit [6:0]   rt;
    int         lat;
    bit [127:0] data;
    int         age;
  } ent_t;
  ent_t q[$];   // q[0] is the youngest

  function automatic int eff_lat(input int l);
    if (l < 1) return 1;
    if (l > PD) return PD;
    return l;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) q.delete();
    else if (!hold) begin
      foreach (q[i]) q[i].age++;
      while (q.size() > 0 && q[q.size()-1].age > PD) void'(q.pop_back());
      if (in_valid) q.push_front('{rt: in_rt, lat: int'(in_lat), data: in_result, age: 1});
    end
  end

  // ---------------- compare process ----------------
  logic         m_found, m_stall, m_hit;
  logic [6:0]   m_wbrt, m_rd;
  logic [127:0] m_wbd, g_data;
  logic         g_hit;
  int           best;

  always @(negedge clk) begin
    m_found = 0; m_wbrt = 0; m_wbd = 0;
    foreach (q[i]) if (q[i].age == PD) begin
      m_found = 1; m_wbrt = q[i].rt; m_wbd = q[i].data;
    end
    chk("wb_en", wb_en, m_found && (flush || !hold));
    if (wb_en && m_found) begin
      chk("wb_rt", wb_rt, m_wbrt);
      chk("wb_data", wb_data, m_wbd);
    end
    m_stall = 0;
    for (int p = 0; p < 3; p++) begin
      m_rd   = (p == 0) ? rd_addr_a : (p == 1) ? rd_addr_b : rd_addr_c;
      g_hit  = (p == 0) ? fwd_hit_a : (p == 1) ? fwd_hit_b : fwd_hit_c;
      g_data = (p == 0) ? fwd_data_a : (p == 1) ? fwd_data_b : fwd_data_c;
      best = -1;
      foreach (q[i]) if (q[i].rt == m_rd && (best < 0 || q[i].age < q[best].age)) best = i;
      if (best < 0) begin
        chk("fwd_hit_nomatch", g_hit, 0);
        chk("fwd_data_nomatch", g_data, 0);
      end else begin
`ifdef SPU_RESULT_FWD_EN
        m_hit = q[best].age >= eff_lat(q[best].lat);
        chk("fwd_hit", g_hit, m_hit);
        if (m_hit) chk("fwd_data", g_data, q[best].data);
        else m_stall = 1;
`else
        chk("fwd_hit_nofwd", g_hit, 0);
        chk("fwd_data_nofwd", g_data, 0);
        m_stall = 1;
`endif
      end
    end
    chk("stall_req", stall_req, m_stall);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 0; hold = 0; flush = 0;
  endtask

  task automatic cap(input logic [6:0] rt, input logic [2:0] lat, input logic [127:0] d);
    in_valid = 1; in_rt = rt; in_lat = lat; in_result = d;
    tick();
    in_valid = 0;
  endtask

  task automatic drain();
    idle();
    repeat (PD + 1) tick();
  endtask

  initial begin
    logic [127:0] pa, d4;
    pa = {8{16'hAAAA}};
    d4 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    tick();

    // Reset state / test 1: entries in flight then async reset.
    cap(7'd1, 3'd1, 128'h11);
    cap(7'd2, 3'd1, 128'h22);
    cap(7'd3, 3'd1, 128'h33);
    rd_addr_a = 1; rd_addr_b = 2; rd_addr_c = 3;
    #2 rst_n = 0;
    #1;
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_rt", wb_rt, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_hit_a", fwd_hit_a, 0);
    chk("rst_data_b", fwd_data_b, 0);
    chk("rst_stall", stall_req, 0);
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < PD + 1; i++) begin
      @(negedge clk); chk("post_rst_wb_en", wb_en, 0);
      tick();
    end
    rd_addr_a = 0; rd_addr_b = 0; rd_addr_c = 0;

    // Test 2: rt=5 lat=2.
    cap(7'd5, 3'd2, pa);
    rd_addr_a = 5;
    @(negedge clk); chk("t2_stall_s1", stall_req, 1);
    tick();
    @(negedge clk);
`ifdef SPU_RESULT_FWD_EN
    chk("t2_hit_s2", fwd_hit_a, 1);
    chk("t2_data_s2", fwd_data_a, pa);
    chk("t2_nostall_s2", stall_req, 0);
`else
    chk("t2_hit_s2", fwd_hit_a, 0);
    chk("t2_stall_s2", stall_req, 1);
`endif
    repeat (5) tick();
    @(negedge clk);
    chk("t2_wb_en", wb_en, 1);
    chk("t2_wb_rt", wb_rt, 5);
    chk("t2_wb_data", wb_data, pa);
    drain();

    // Test 3: back-to-back rt=9, younger pending masks older.
    cap(7'd9, 3'd1, 128'd1);
    cap(7'd9, 3'd4, 128'd2);
    rd_addr_a = 9;
    @(negedge clk);
    chk("t3_stall", stall_req, 1);
    chk("t3_hit", fwd_hit_a, 0);
    drain();

    // Test 4: hold with entry at stage 6.
    cap(7'd3, 3'd1, d4);
    repeat (5) tick();
    hold = 1; in_valid = 1; in_rt = 7'd30; in_lat = 3'd1; in_result = '1;
    rd_addr_a = 30;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("t4_hold_wb_en", wb_en, 0);
      tick();
    end
    hold = 0; in_valid = 0;
    @(negedge clk); chk("t4_s6_wb_en", wb_en, 0);
    tick();
    @(negedge clk);
    chk("t4_wb_en", wb_en, 1);
    chk("t4_wb_rt", wb_rt, 3);
    chk("t4_wb_data", wb_data, d4);
    chk("t4_no_hold_capture", stall_req, 0);
    drain();

    // Test 5: flush with entries at stages 2 and 7.
    cap(7'd11, 3'd1, 128'hB0B);
    repeat (4) tick();
    cap(7'd12, 3'd1, 128'hC0C);
    tick();
    flush = 1; rd_addr_a = 12;
    @(negedge clk);
    chk("t5_wb_en", wb_en, 1);
    chk("t5_wb_rt", wb_rt, 11);
    tick();
    flush = 0;
    @(negedge clk);
    chk("t5_miss_hit", fwd_hit_a, 0);
    chk("t5_miss_stall", stall_req, 0);
    for (int i = 0; i < PD; i++) begin
      @(negedge clk); chk("t5_no_wb", wb_en, 0);
      tick();
    end

    // Test 6: latency clamp.
    cap(7'd20, 3'd0, 128'h2020);
    rd_addr_a = 20;
    @(negedge clk);
`ifdef SPU_RESULT_FWD_EN
    chk("t6_lat0_hit", fwd_hit_a, 1);
`else
    chk("t6_lat0_hit", fwd_hit_a, 0);
    chk("t6_lat0_stall", stall_req, 1);
`endif
    drain();
    cap(7'd21, 3'd7, 128'h2121);
    rd_addr_a = 21;
    repeat (5) tick();
    @(negedge clk);
    chk("t6_lat7_s6_stall", stall_req, 1);
    chk("t6_lat7_s6_hit", fwd_hit_a, 0);
    tick();
    @(negedge clk);
`ifdef SPU_RESULT_FWD_EN
    chk("t6_lat7_s7_hit", fwd_hit_a, 1);
`else
    chk("t6_lat7_s7_hit", fwd_hit_a, 0);
    chk("t6_lat7_s7_stall", stall_req, 1);
`endif
    drain();

    // Randomized phase; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(9, 0) < 6);
      in_rt     = 7'($urandom_range(7, 0));
      in_lat    = 3'($urandom_range(7, 0));
      in_result = {$urandom, $urandom, $urandom, $urandom};
      hold      = ($urandom_range(99, 0) < 15);
      flush     = ($urandom_range(99, 0) < 5);
      rd_addr_a = 7'($urandom_range(7, 0));
      rd_addr_b = 7'($urandom_range(7, 0));
      rd_addr_c = 7'($urandom_range(7, 0));
      if ($urandom_range(199, 0) == 0) begin
        rst_n = 0; tick(); rst_n = 1;
      end else tick();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
